game_input_ctrl: RTL and testbench
==================================

# game_input_ctrl

Parametrised pushbutton front end for the Flappy Bird game. It sits between the board pushbuttons and the `game` module. It replaces scripted stimulus with real input handling: per-button synchronisation, debounce and press detection, a pause toggle, and flap/reset requests stretched to one full game tick. An optional compile-time autoplay generator issues periodic flaps for unattended demos.

## Interface
- `N_BTN`, default 3: number of buttons, must be ≥3. Index 0 = flap, 1 = pause, 2 = game reset; higher indices are debounced only.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable `clk` cycles (10 ms at 100 MHz) before a level change is accepted. Must be ≥1.
- `DEMO_PERIOD`, default 50: game ticks between autoplay flaps (1 s at 50 Hz). Must be ≥1.
- `clk`  in  1  100 MHz master clock; all logic in this single domain.
- `clr`  in  1  reset, **asynchronous, active-low** (asserted when 0).
- `btn_raw`  in  N_BTN  raw pushbuttons, active-high, asynchronous to `clk`.
- `game_tick`  in  1  one-`clk` strobe at the game rate (50 Hz).
- `demo_en`  in  1  autoplay request; only honoured with `DEMO_AUTOPLAY_EN`.
- `btn_level`  out  N_BTN  debounced button levels.
- `btn_press`  out  N_BTN  one-`clk` pulse on each debounced 0→1 transition.
- `flap`  out  1  flap request, valid for exactly one game-tick period.
- `paused`  out  1  pause state.
- `game_reset`  out  1  game reset request, valid for one game-tick period.
- `demo_active`  out  1  autoplay currently generating flaps.

## Operation
- Per button: 2-FF synchroniser, then a debounce counter. The counter increments while the synchronised input differs from `btn_level`. It clears when the input matches `btn_level` again. When the count reaches `DEBOUNCE_CYCLES`, the level flips and the counter clears.
- `btn_press[i]` is `btn_level[i]` & !previous `btn_level[i]`. No press pulse is generated on release.
- Flap pending latch `flap_pend`:
  - Sets on `btn_press[0]`, or on an autoplay flap.
  - On `game_tick`: `flap <= flap_pend | set_this_cycle`, and `flap_pend` clears.
  - `flap` holds until the next `game_tick`. Multiple presses within one tick period collapse to one flap.
- `game_reset` uses the same pend/tick mechanism, driven by `btn_press[2]`.
- `paused`:
  - Toggles on `btn_press[1]`.
  - Forced to 0 in the same cycle `game_reset` is loaded as 1. Reset wins over a simultaneous toggle.
- While `paused`=1, flap requests are discarded: `flap_pend` is not set and `flap` loads 0 at the tick. Reset requests are still accepted.

## Timing
- Reset: all outputs and internal state are 0, with all debounce counters and synchronisers at 0.
- Press latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 cycle to `btn_level`. `btn_press` follows in the same cycle as the `btn_level` rise.
- Flap latency: the `flap` rise occurs on the first `game_tick` at or after the `btn_press` cycle. A press and a tick in the same cycle count as captured.
- A glitch shorter than `DEBOUNCE_CYCLES` produces no level change.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). Counts never wrap because the clear happens at the terminal count.
- `clr` asserted mid-debounce or mid-tick-period aborts immediately. No pending request survives reset.

## Configuration
- Macro `DEMO_AUTOPLAY_EN`.
- Defined:
  - A tick counter of width $clog2(DEMO_PERIOD+1) runs while `demo_en` & !`paused`.
  - On reaching `DEMO_PERIOD` ticks, it raises an autoplay flap into `flap_pend` and restarts.
  - The counter clears when `demo_en`=0, when `paused`=1, or on `game_reset`.
  - `demo_active` = `demo_en` & !`paused`.
- Undefined: `demo_en` is ignored, `demo_active` is tied 0, and no counter logic is present.

## Structure
- Shared package `game_pkg` holds the button index constants `BTN_FLAP`=0, `BTN_PAUSE`=1 and `BTN_RESET`=2, plus the default `DEBOUNCE_CYCLES`.
- One sub-module, `btn_debounce` (synchroniser + counter + edge detect, single bit), is instantiated N_BTN times via generate.
- Pend/tick latches, pause and autoplay logic live in `game_input_ctrl`.

## Test plan
- Debounce: use `DEBOUNCE_CYCLES`=8. Pulse `btn_raw[0]` high for 5 cycles → `btn_level`/`btn_press` stay 0. Hold for 20 cycles → `btn_level[0]` rises 11 cycles after the edge, with one `btn_press[0]` pulse.
- Flap stretch: press btn0, then `game_tick` 30 cycles later → `flap`=1 from that tick until the next tick, then 0. Two presses between ticks → a single flap period.
- Simultaneous: `btn_press[0]` in the same cycle as `game_tick` → `flap`=1 from that tick.
- Pause and reset priority:
  - Press btn1 → `paused`=1; btn0 presses then yield `flap`=0.
  - Press btn1 and btn2 so their presses coincide → `paused`=0 and `game_reset`=1 for one tick period.
- Reset mid-operation: assert `clr`=0 while `flap_pend`=1 and a debounce count is at 5 → after release, all outputs are 0 and no flap appears on the next tick.
- Autoplay (`DEMO_AUTOPLAY_EN`, `DEMO_PERIOD`=3):
  - `demo_en`=1 → `flap` periods on every 3rd tick and `demo_active`=1.
  - Set `paused`=1 → flaps stop, `demo_active`=0, and the counter restarts from 0 on unpause.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the Flappy Bird input front end: button roles and
// the default debounce interval (10 ms at 100 MHz).
package game_pkg;

  localparam int unsigned BTN_FLAP  = 0;
  localparam int unsigned BTN_PAUSE = 1;
  localparam int unsigned BTN_RESET = 2;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage

// File: rtl/game_input_ctrl_if.sv
// Button/game-side signal bundle of game_input_ctrl. The master drives raw
// buttons, the game tick and the demo request; the slave returns the results.
interface game_input_ctrl_if #(
  parameter int unsigned N_BTN = 3
);

  logic [N_BTN-1:0] btn_raw;
  logic             game_tick;
  logic             demo_en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic             flap;
  logic             paused;
  logic             game_reset;
  logic             demo_active;

  modport master (
    output btn_raw, game_tick, demo_en,
    input  btn_level, btn_press, flap, paused, game_reset, demo_active
  );

  modport slave (
    input  btn_raw, game_tick, demo_en,
    output btn_level, btn_press, flap, paused, game_reset, demo_active
  );

endinterface

// File: rtl/game_input_ctrl_btn_debounce.sv
// Single-bit button conditioner: 2-FF synchroniser, stability counter that
// flips the level after DEBOUNCE_CYCLES+1 differing samples, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_level <= 1'b0;
      level_d   <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= btn_level;
      if (sync2 == btn_level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        // terminal count: accept the new level, restart from zero
        cnt       <= '0;
        btn_level <= ~btn_level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign btn_press = btn_level & ~level_d;

endmodule

// File: rtl/game_input_ctrl.sv
// Pushbutton front end for the game: debounce per button, flap/reset requests
// stretched to one game tick, pause toggle. Optional autoplay: DEMO_AUTOPLAY_EN.
module game_input_ctrl
  import game_pkg::*;
#(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned DEMO_PERIOD     = 50
) (
  input logic               clk,
  input logic               clr,
  game_input_ctrl_if.slave  bus
);

  logic [N_BTN-1:0] level, press;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk      (clk),
      .clr      (clr),
      .btn_raw  (bus.btn_raw[i]),
      .btn_level(level[i]),
      .btn_press(press[i])
    );
  end

  assign bus.btn_level = level;
  assign bus.btn_press = press;

  logic flap_q, paused_q, reset_q;
  logic flap_pend, rst_pend;
  logic demo_fire, flap_set, rst_set, rst_load;

  always_comb begin
    flap_set = (press[BTN_FLAP] | demo_fire) & ~paused_q;
    rst_set  = press[BTN_RESET];
    rst_load = bus.game_tick & (rst_pend | rst_set);
  end

  // A request arriving in the tick cycle itself is captured by that tick.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      flap_q    <= 1'b0;
      flap_pend <= 1'b0;
      reset_q   <= 1'b0;
      rst_pend  <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      if (bus.game_tick) begin
        flap_q    <= ~paused_q & (flap_pend | flap_set);
        flap_pend <= 1'b0;
        reset_q   <= rst_pend | rst_set;
        rst_pend  <= 1'b0;
      end else begin
        flap_pend <= flap_pend | flap_set;
        rst_pend  <= rst_pend | rst_set;
      end
      if (rst_load) begin
        paused_q <= 1'b0;
      end else if (press[BTN_PAUSE]) begin
        paused_q <= ~paused_q;
      end
    end
  end

  assign bus.flap       = flap_q;
  assign bus.paused     = paused_q;
  assign bus.game_reset = reset_q;

`ifdef DEMO_AUTOPLAY_EN
  localparam int unsigned DW = $clog2(DEMO_PERIOD + 1);

  logic [DW-1:0] demo_cnt;
  logic          demo_run;

  assign demo_run  = bus.demo_en & ~paused_q;
  assign demo_fire = demo_run & ~reset_q & bus.game_tick &
                     (demo_cnt == DW'(DEMO_PERIOD - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      demo_cnt <= '0;
    end else if (!demo_run || reset_q) begin
      demo_cnt <= '0;
    end else if (bus.game_tick) begin
      demo_cnt <= demo_fire ? '0 : demo_cnt + 1'b1;
    end
  end

  assign bus.demo_active = demo_run;
`else
  assign demo_fire       = 1'b0;
  assign bus.demo_active = 1'b0;
`endif

endmodule

// File: tb/tb_game_input_ctrl.sv
// Scoreboard bench for game_input_ctrl: stimulus pushes expected per-cycle
// outputs from a rule-level model; a negedge monitor pops and compares.
module tb_game_input_ctrl;
  import game_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned DP = 3;

  typedef logic [2*NB+3:0] obs_t;

  logic clk;
  logic clr;

  game_input_ctrl_if #(.N_BTN(NB)) bus ();

  game_input_ctrl #(
    .N_BTN          (NB),
    .DEBOUNCE_CYCLES(DB),
    .DEMO_PERIOD    (DP)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  obs_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // reference model state
  bit          hist[NB][$];
  bit [NB-1:0] m_level, m_press;
  bit          m_flap, m_fpend, m_rpend, m_greset, m_paused;
  int          m_dcnt;

  logic [NB-1:0] cur_raw;
  logic          cur_de;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      hist[i].delete();
      repeat (DB + 3) hist[i].push_back(1'b0);
    end
    m_level = '0; m_press = '0;
    m_flap = 0; m_fpend = 0; m_rpend = 0; m_greset = 0; m_paused = 0;
    m_dcnt = 0;
  endfunction

  function automatic obs_t expected();
    bit da;
`ifdef DEMO_AUTOPLAY_EN
    da = bus.demo_en && !m_paused;
`else
    da = 1'b0;
`endif
    return {m_level, m_press, m_flap, m_paused, m_greset, da};
  endfunction

  // One clock edge of the specified behaviour, using the inputs held across it.
  function automatic void model_edge();
    bit fire, fs, rs, np, old, all_diff;
    int last;
    if (!clr) begin
      model_reset();
      return;
    end
    fire = 0;
`ifdef DEMO_AUTOPLAY_EN
    if (!bus.demo_en || m_paused || m_greset) m_dcnt = 0;
    else if (bus.game_tick) begin
      m_dcnt++;
      if (m_dcnt == DP) begin fire = 1; m_dcnt = 0; end
    end
`endif
    fs = (m_press[BTN_FLAP] || fire) && !m_paused;
    rs = m_press[BTN_RESET];
    np = m_paused;
    if (bus.game_tick && (m_rpend || rs)) np = 0;
    else if (m_press[BTN_PAUSE]) np = !m_paused;
    if (bus.game_tick) begin
      m_flap   = !m_paused && (m_fpend || fs);
      m_greset = m_rpend || rs;
      m_fpend  = 0;
      m_rpend  = 0;
    end else begin
      m_fpend = m_fpend || fs;
      m_rpend = m_rpend || rs;
    end
    m_paused = np;
    // level flips once DB+1 consecutive synchronised samples disagree with it
    for (int i = 0; i < NB; i++) begin
      hist[i].push_back(bus.btn_raw[i]);
      last = hist[i].size() - 1;
      all_diff = 1;
      for (int k = 0; k <= DB; k++)
        if (hist[i][last-2-k] == m_level[i]) all_diff = 0;
      old = m_level[i];
      if (all_diff) m_level[i] = !m_level[i];
      m_press[i] = m_level[i] && !old;
      void'(hist[i].pop_front());
    end
  endfunction

  task automatic drive(input logic [NB-1:0] raw, input logic tk,
                       input logic de, input logic rst_n);
    bus.btn_raw   = raw;
    bus.game_tick = tk;
    bus.demo_en   = de;
    clr           = rst_n;
    if (!rst_n) model_reset();
    q.push_back(expected());
    @(posedge clk);
    #1 model_edge();
  endtask

  task automatic run(input int n);
    repeat (n) drive(cur_raw, 1'b0, cur_de, 1'b1);
  endtask

  task automatic tick1();
    drive(cur_raw, 1'b1, cur_de, 1'b1);
  endtask

  task automatic press_btn(input int b);
    cur_raw[b] = 1'b1; run(14);
    cur_raw[b] = 1'b0; run(14);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {bus.btn_level, bus.btn_press, bus.flap, bus.paused,
             bus.game_reset, bus.demo_active};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL outputs t=%0t got=%b want=%b (level|press|flap,paused,reset,demo)",
                   $time, a, e);
        end
      end
    end
  end

  initial begin : stim
    cur_raw = '0;
    cur_de  = 1'b0;
    clr     = 1'b0;
    bus.btn_raw = '0; bus.game_tick = 1'b0; bus.demo_en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) drive('0, 1'b0, 1'b0, 1'b0);
    run(4);

    // short glitch, then a real press
    cur_raw[0] = 1'b1; run(5);
    cur_raw[0] = 1'b0; run(15);
    cur_raw[0] = 1'b1; run(20);
    cur_raw[0] = 1'b0; run(15);

    // flap stretch and double press inside one tick period
    press_btn(0); run(2); tick1(); run(20); tick1(); run(5);
    press_btn(0); press_btn(0); tick1(); run(10); tick1(); run(5);

    // tick around the press cycle, including coincident
    for (int off = 9; off <= 13; off++) begin
      cur_raw[0] = 1'b1;
      for (int k = 0; k < 16; k++) drive(cur_raw, k == off, cur_de, 1'b1);
      cur_raw[0] = 1'b0; run(14);
      tick1(); run(3);
    end

    // pause discards flaps; coincident pause+reset presses
    press_btn(1); press_btn(0); tick1(); run(4); tick1();
    cur_raw[1] = 1'b1; cur_raw[2] = 1'b1; run(14);
    cur_raw[1] = 1'b0; cur_raw[2] = 1'b0; run(5);
    tick1(); run(6); tick1(); run(4);

    // reset with a pending flap and a debounce mid-count
    press_btn(0);
    cur_raw[3] = 1'b1; run(7);
    cur_raw = '0;
    drive(cur_raw, 1'b0, cur_de, 1'b0);
    drive(cur_raw, 1'b1, cur_de, 1'b0);
    run(3); tick1(); run(5); tick1(); run(3);

    // autoplay with a pause in the middle
    cur_de = 1'b1;
    repeat (8) begin run(3); tick1(); end
    press_btn(1);
    repeat (4) begin run(3); tick1(); end
    press_btn(1);
    repeat (8) begin run(3); tick1(); end
    cur_de = 1'b0;
    run(5);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 13) == 0) cur_raw[b] = ~cur_raw[b];
      if ($urandom_range(0, 199) == 0) cur_de = ~cur_de;
      if ($urandom_range(0, 1499) == 0)
        drive(cur_raw, 1'b0, cur_de, 1'b0);
      else
        drive(cur_raw, $urandom_range(0, 11) == 0, cur_de, 1'b1);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
